// File: rtl/led_pattern_scheduler_pkg.sv
// Shared encodings for the LED pattern scheduler.
// Optional pause input is enabled by LED_PAUSE_EN.
package led_sched_pkg;

  localparam logic [1:0] MODE_SHIFT_L = 2'd0;
  localparam logic [1:0] MODE_SHIFT_R = 2'd1;
  localparam logic [1:0] MODE_BOUNCE  = 2'd2;
  localparam logic [1:0] MODE_BLINK   = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  localparam logic [3:0] STEPS_SHIFT_L = 4'd5;
  localparam logic [3:0] STEPS_SHIFT_R = 4'd5;
  localparam logic [3:0] STEPS_BOUNCE  = 4'd8;
  localparam logic [3:0] STEPS_BLINK   = 4'd2;

  // Index of the boundary step of a mode's cycle.
  function automatic logic [2:0] last_step(
    input logic [1:0] m
  );
    logic [3:0] n;
    n = STEPS_SHIFT_L;
    unique case (1'b1)
      (m == MODE_SHIFT_L): n = STEPS_SHIFT_L;
      (m == MODE_SHIFT_R): n = STEPS_SHIFT_R;
      (m == MODE_BOUNCE):  n = STEPS_BOUNCE;
      (m == MODE_BLINK):   n = STEPS_BLINK;
      default:             n = STEPS_SHIFT_L;
    endcase
    return 3'(n - 4'd1);
  endfunction

endpackage

// File: rtl/led_pattern_scheduler_if.sv
// Mode-change request/acknowledge handshake bundle.
// Unaffected by LED_PAUSE_EN.
interface led_pattern_scheduler_if;

  logic       mode_req;
  logic [1:0] mode_sel;
  logic       mode_busy;
  logic       mode_ack;

  modport master (
    output mode_req,
    output mode_sel,
    input  mode_busy,
    input  mode_ack
  );

  modport slave (
    input  mode_req,
    input  mode_sel,
    output mode_busy,
    output mode_ack
  );

endinterface

// File: rtl/led_pattern_scheduler_tick_gen.sv
// Prescaler producing a registered one-cycle step enable.
// LED_PAUSE_EN adds a pause input that freezes the count.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
`ifdef LED_PAUSE_EN
  input  logic pause,
`endif
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          w_hold;

`ifdef LED_PAUSE_EN
  assign w_hold = pause;
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (w_hold) begin
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/led_pattern_scheduler.sv
// LED animation sequencer with boundary-aligned mode switching.
// Define LED_PAUSE_EN to add the pause input.
module led_pattern_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned LED_W    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef LED_PAUSE_EN
  input  logic                 pause,
`endif
  led_pattern_scheduler_if.slave mode_if,
  output logic [1:0]           cur_mode,
  output logic                 step_tick,
  output logic [LED_W-1:0]     led
);

  function automatic logic [LED_W-1:0] pattern(
    input logic [1:0] m,
    input logic [2:0] s
  );
    int p;
    logic [LED_W-1:0] v;
    v = '0;
    p = 0;
    unique case (1'b1)
      (m == MODE_SHIFT_L): v = LED_W'(1) << s;
      (m == MODE_SHIFT_R): v = LED_W'(1) << (LED_W - 1 - int'(s));
      (m == MODE_BOUNCE): begin
        p = (int'(s) < int'(LED_W)) ? int'(s)
                                    : (2 * LED_W - 2 - int'(s));
        v = LED_W'(1) << p;
      end
      (m == MODE_BLINK): v = (s == 3'd0) ? '1 : '0;
      default:           v = '0;
    endcase
    return v;
  endfunction

  logic [1:0]       r_state;
  logic [1:0]       r_mode;
  logic [1:0]       r_pend;
  logic [2:0]       r_step;
  logic             r_run;
  logic             r_busy;
  logic             r_ack;
  logic [LED_W-1:0] r_led;

  logic             w_tick;
  logic             w_last;
  logic [2:0]       w_next;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
`ifdef LED_PAUSE_EN
    .pause (pause),
`endif
    .tick  (w_tick)
  );

  assign w_last = (r_step == last_step(r_mode));
  assign w_next = w_last ? 3'd0 : r_step + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_SHIFT_L;
      r_pend  <= MODE_SHIFT_L;
      r_step  <= '0;
      r_run   <= 1'b0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_led   <= '0;
    end else begin
      r_ack <= 1'b0;
      unique case (1'b1)
        (r_state == ST_IDLE): begin
          if (w_tick) begin
            r_step  <= '0;
            r_led   <= pattern(r_mode, 3'd0);
            r_run   <= 1'b1;
            r_state <= ST_RUN;
          end
          if (mode_if.mode_req) begin
            r_pend  <= mode_if.mode_sel;
            r_busy  <= 1'b1;
            r_state <= ST_PEND;
          end
        end
        (r_state == ST_RUN): begin
          if (w_tick) begin
            r_step <= w_next;
            r_led  <= pattern(r_mode, w_next);
          end
          if (mode_if.mode_req) begin
            r_pend  <= mode_if.mode_sel;
            r_busy  <= 1'b1;
            r_state <= ST_PEND;
          end
        end
        (r_state == ST_PEND): begin
          // A request taken in IDLE must first show step 0 of the old mode.
          if (w_tick) begin
            if (!r_run) begin
              r_step <= '0;
              r_led  <= pattern(r_mode, 3'd0);
              r_run  <= 1'b1;
            end else if (w_last) begin
              r_mode  <= r_pend;
              r_step  <= '0;
              r_led   <= pattern(r_pend, 3'd0);
              r_busy  <= 1'b0;
              r_ack   <= 1'b1;
              r_state <= ST_RUN;
            end else begin
              r_step <= w_next;
              r_led  <= pattern(r_mode, w_next);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mode_if.mode_busy = r_busy;
  assign mode_if.mode_ack  = r_ack;
  assign cur_mode          = r_mode;
  assign step_tick         = w_tick;
  assign led               = r_led;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Scoreboard bench for led_pattern_scheduler (TICK_DIV=4).
// Pause scenario is exercised when LED_PAUSE_EN is defined.
module tb_led_pattern_scheduler;

  typedef struct packed {
    logic [4:0] led;
    logic [1:0] mode;
    logic       ack;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] cur_mode;
  logic       step_tick;
  logic [4:0] led;
`ifdef LED_PAUSE_EN
  logic       pause;
`endif

  led_pattern_scheduler_if sif ();

  led_pattern_scheduler #(
    .TICK_DIV (4),
    .LED_W    (5)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
`ifdef LED_PAUSE_EN
    .pause     (pause),
`endif
    .mode_if   (sif.slave),
    .cur_mode  (cur_mode),
    .step_tick (step_tick),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_ack  = 0;
  logic seen   = 1'b0;

  // Monitor: an update is presented on the cycle after a step tick.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (seen) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL upd_unexpected led=%b mode=%0d", led, cur_mode);
        end else begin
          e = q.pop_front();
          if ({led, cur_mode, sif.mode_ack} !== e) begin
            errors++;
            $display("FAIL upd got led=%b mode=%0d ack=%b want led=%b mode=%0d ack=%b",
                     led, cur_mode, sif.mode_ack, e.led, e.mode, e.ack);
          end
        end
      end
      if (sif.mode_ack) begin
        n_ack++;
        checks++;
        if (sif.mode_busy) begin
          errors++;
          $display("FAIL busy_ack_overlap got busy=1 want busy=0");
        end
      end
      seen = step_tick;
    end
  end

  task automatic push(input logic [4:0] l, input logic [1:0] m,
                      input logic a = 1'b0);
    q.push_back('{led: l, mode: m, ack: a});
  endtask

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d pending want=0", q.size());
      q.delete();
    end
  endtask

  task automatic pulse_req(input logic [1:0] s);
    sif.mode_req = 1'b1;
    sif.mode_sel = s;
    @(negedge clk); #1;
    sif.mode_req = 1'b0;
  endtask

  task automatic idle_start();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("idle_led", 8'(led), 8'h00);
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    sif.mode_req = 1'b0;
    sif.mode_sel = 2'd0;
`ifdef LED_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_led", 8'(led), 8'h00);
    chk("rst_mode", 8'(cur_mode), 8'h00);
    chk("rst_busy", 8'(sif.mode_busy), 8'h00);
    chk("rst_ack", 8'(sif.mode_ack), 8'h00);
    chk("rst_tick", 8'(step_tick), 8'h00);
    rst_n = 1'b1;

    // Free-running SHIFT_L from reset.
    push(5'b00001, 0); push(5'b00010, 0); push(5'b00100, 0);
    push(5'b01000, 0); push(5'b10000, 0); push(5'b00001, 0);
    idle_start();
    drain();

    // Switch to BLINK requested at s=2.
    push(5'b00010, 0); push(5'b00100, 0);
    drain();
    pulse_req(2'd3);
    chk("busy_blink", 8'(sif.mode_busy), 8'h01);
    push(5'b01000, 0); push(5'b10000, 0);
    push(5'b11111, 3, 1'b1);
    push(5'b00000, 3); push(5'b11111, 3); push(5'b00000, 3);
    drain();

    // Second request while pending is ignored.
    sif.mode_req = 1'b1;
    sif.mode_sel = 2'd2;
    @(negedge clk); #1;
    sif.mode_sel = 2'd1;
    @(negedge clk); #1;
    sif.mode_req = 1'b0;
    chk("busy_bounce", 8'(sif.mode_busy), 8'h01);
    push(5'b00001, 2, 1'b1);
    push(5'b00010, 2); push(5'b00100, 2); push(5'b01000, 2);
    push(5'b10000, 2); push(5'b01000, 2); push(5'b00100, 2);
    push(5'b00010, 2); push(5'b00001, 2);
    drain();

    // Same-mode request restarts the pattern.
    push(5'b00010, 2);
    drain();
    pulse_req(2'd2);
    push(5'b00100, 2); push(5'b01000, 2); push(5'b10000, 2);
    push(5'b01000, 2); push(5'b00100, 2); push(5'b00010, 2);
    push(5'b00001, 2, 1'b1);
    drain();

    // Request coinciding with a step tick.
    k = 0;
    while (step_tick !== 1'b1 && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    chk("tick_seen", 8'(step_tick), 8'h01);
    push(5'b00010, 2); push(5'b00100, 2); push(5'b01000, 2);
    push(5'b10000, 2); push(5'b01000, 2); push(5'b00100, 2);
    push(5'b00010, 2);
    push(5'b11111, 3, 1'b1);
    pulse_req(2'd3);
    chk("busy_tickreq", 8'(sif.mode_busy), 8'h01);
    drain();

    // Asynchronous reset between edges discards a pending request.
    pulse_req(2'd1);
    chk("busy_pre_rst", 8'(sif.mode_busy), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_led", 8'(led), 8'h00);
    chk("arst_mode", 8'(cur_mode), 8'h00);
    chk("arst_busy", 8'(sif.mode_busy), 8'h00);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    push(5'b00001, 0); push(5'b00010, 0); push(5'b00100, 0);
    idle_start();
    drain();
`ifdef LED_PAUSE_EN
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("pause_led", 8'(led), 8'h04);
      chk("pause_tick", 8'(step_tick), 8'h00);
    end
    pause = 1'b0;
`endif
    push(5'b01000, 0); push(5'b10000, 0); push(5'b00001, 0);
    drain();

    // Request in IDLE: old mode step 0 shows first, switch at boundary.
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    pulse_req(2'd1);
    chk("busy_idle", 8'(sif.mode_busy), 8'h01);
    push(5'b00001, 0); push(5'b00010, 0); push(5'b00100, 0);
    push(5'b01000, 0); push(5'b10000, 0);
    push(5'b10000, 1, 1'b1);
    push(5'b01000, 1);
    drain();

    chk("ack_count", 8'(n_ack), 8'd5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
